// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage. Owns the PC and addresses the instruction ROM. Returned
//            instructions are buffered with their PCs for a valid/ready decode
//            handshake. Execute can redirect fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err
);

    localparam int                 c_PTR_W  = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1  = c_PTR_W'(1);

    logic [31:0]        r_fpc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic               r_misalign;
    logic [31:0]        r_buf_instr [DEPTH];
    logic [31:0]        r_buf_pc    [DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign w_push  = en & ~redirect_valid & ((r_count < c_DEPTH) | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc      <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            // Flush everything, including an entry decode took this cycle.
            r_fpc    <= {redirect_pc[31:2], 2'b00};
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else begin
            if (w_push) begin
                r_fpc    <= r_fpc + 32'd4;
                r_wr_ptr <= r_wr_ptr + c_PTR_1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_1;
                2'b01:   r_count <= r_count - c_CNT_1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= rom_instr;
            r_buf_pc[r_wr_ptr]    <= r_fpc;
        end
    end

    assign rom_addr     = r_fpc;
    assign out_valid    = w_valid;
    assign out_instr    = w_valid ? r_buf_instr[r_rd_ptr] : 32'd0;
    assign out_pc       = w_valid ? r_buf_pc[r_rd_ptr] : 32'd0;
    assign out_pc_plus4 = w_valid ? (r_buf_pc[r_rd_ptr] + 32'd4) : 32'd0;
    assign misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM word address.
- Captures each returned instruction together with its PC into a 2-entry buffer.
- Presents instructions to decode over a valid/ready handshake and accepts branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- en  input  1  fetch enable; 0 freezes fetch (buffer may still drain)
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_pc  input  32  redirect target byte address
- rom_addr  output  32  byte address to ROM; equals fetch PC, combinational from the register
- rom_instr  input  32  ROM data for rom_addr, same cycle
- out_valid  output  1  buffer head holds a valid instruction
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  32  head instruction; 0 when empty
- out_pc  output  32  head PC; 0 when empty
- out_pc_plus4  output  32  out_pc+4 when valid; 0 when empty
- misalign_err  output  1  sticky: a misaligned redirect was received

Behaviour:
- Reset (rst=0, async, any time):
  - fpc=RESET_PC, so rom_addr=RESET_PC.
  - Buffer count=0, read/write pointers=0.
  - out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, misalign_err=0.
  - In-flight entries are discarded.
- pop = out_valid & out_ready.
- push = en & ~redirect_valid & (count<DEPTH | pop).
  - On push: write {fpc, rom_instr} at wr_ptr; fpc <= fpc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000).
- Simultaneous push and pop: both occur, count unchanged; this holds when full too, since pop frees the slot.
- Full and no pop: no push, fpc holds, so rom_addr is stable (stall).
- en=0: no push, fpc holds; pops continue normally.
- Redirect, highest priority, on the edge where redirect_valid=1:
  - count <= 0 and pointers reset; all buffered entries flushed, including any popped in that same cycle (decode is being flushed too).
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - If redirect_pc[1:0]!=0, misalign_err <= 1 and stays set until reset.
- Latency:
  - Push-to-valid is 1 cycle: out_valid rises the cycle after the push edge.
  - Redirect-to-valid is 2 cycles: redirect edge, then push edge, then valid.
  - With en=1 and out_ready=1 held, throughput is 1 instruction/cycle.
- out_valid = (count!=0). Head fields are registered buffer contents, never combinational from rom_instr.
- Count is a ptr-width+1 counter; it never exceeds DEPTH and never underflows (pop is only possible when valid).
- Back-to-back redirects: the last one wins; no push occurs in any redirect cycle.

Test Plan:
- Reset release, en=1, out_ready=1, ROM[0..3]=8C010000, 8C020004, 00221820, AC030008 -> out_valid from cycle 1; out_pc 0,4,8,C with matching out_instr; out_pc_plus4 4,8,C,10.
- out_ready=0 for 5 cycles from PC=0 -> after 2 pushes, count=2 and rom_addr holds 8. On release, outputs PC 0,4,8 in order with no drop or duplicate.
- Buffer full with out_ready=1 -> push+pop every cycle, count stays 2, one instruction per cycle.
- Redirect redirect_pc=0x40 while 2 entries buffered -> next cycle out_valid=0, rom_addr=0x40; the cycle after, out_pc=0x40 with ROM[16].
- Redirect redirect_pc=0x42 -> misalign_err=1, fetch from 0x40; err stays 1 through later redirects until rst=0.
- Assert rst=0 mid-stream with count=1 -> all outputs 0 and rom_addr=RESET_PC immediately; refetch from RESET_PC after release.
